partition_tx: RTL

Outbound half of the partition-boundary interface. It accepts up to N packets per cycle from the nodes of this partition and captures only those whose destination partition differs from PID. It then serializes the captured packets, one per cycle, onto the single inter-partition link using a valid/ready handshake and round-robin arbitration. The block is the transmit-side counterpart of the receive-side destination filter, which keeps packets whose nexthop partition ID equals its own.

---
 rtl/partition_tx_if.sv | 30 +++
 rtl/partition_tx.sv | 102 ++++++++++
 2 files changed

// File: rtl/partition_tx_if.sv
// Bundle of the slot-side capture signals and the inter-partition link for partition_tx.
// The slave modport is the block's view; the master modport is the driving environment's view.
interface partition_tx_if #(
  parameter int N         = 8,
  parameter int D_WIDTH   = 32,
  parameter int CNT_WIDTH = 16,
  parameter int A_WIDTH   = 11,
  parameter int SW        = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]         in_valid;
  logic [N*A_WIDTH-1:0] in_nexthop;
  logic [N*D_WIDTH-1:0] in_data;
  logic [N-1:0]         in_ack;
  logic                 out_valid;
  logic [A_WIDTH-1:0]   out_nexthop;
  logic [D_WIDTH-1:0]   out_data;
  logic [SW-1:0]        out_src;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] tx_count;

  modport master (
    output in_valid, in_nexthop, in_data, out_ready,
    input  in_ack, out_valid, out_nexthop, out_data, out_src, tx_count
  );

  modport slave (
    input  in_valid, in_nexthop, in_data, out_ready,
    output in_ack, out_valid, out_nexthop, out_data, out_src, tx_count
  );
endinterface

// File: rtl/partition_tx.sv
// Outbound partition-boundary port: captures remote packets into per-slot holding
// registers and serializes them round-robin onto a single valid/ready link.
module partition_tx #(
  parameter int       N         = 8,
  parameter logic [3:0] PID     = 4'h0,
  parameter int       D_WIDTH   = 32,
  parameter int       CNT_WIDTH = 16
) (
  input logic           clock,
  input logic           reset,
  partition_tx_if.slave bus
);
  localparam int AW = 11;
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]              full_q, full_d;
  logic [N-1:0][AW-1:0]      nh_q, nh_d;
  logic [N-1:0][D_WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]             rr_q, rr_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

  logic [SW-1:0] sel;
  logic          found, any, xfer;
  logic [N-1:0]  remote, send, ack;

  // First full slot at or after rr_q, wrapping modulo N.
  always_comb begin
    logic [SW-1:0] cand;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int j = 0; j < N; j++) begin
      cand = SW'((int'(rr_q) + j) % N);
      if (!found && full_q[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  assign any  = |full_q;
  assign xfer = any & bus.out_ready;

  always_comb begin
    remote = '0;
    send   = '0;
    ack    = '0;
    for (int i = 0; i < N; i++) begin
      remote[i] = (bus.in_nexthop[i*AW+7 +: 4] != PID);
      send[i]   = xfer && (sel == SW'(i));
      ack[i]    = !reset && bus.in_valid[i] && remote[i] && (!full_q[i] || send[i]);
    end
  end

  // A capture on a draining slot overwrites it, so full stays set.
  always_comb begin
    full_d = full_q;
    nh_d   = nh_q;
    data_d = data_q;
    for (int i = 0; i < N; i++) begin
      if (ack[i]) begin
        full_d[i] = 1'b1;
        nh_d[i]   = bus.in_nexthop[i*AW +: AW];
        data_d[i] = bus.in_data[i*D_WIDTH +: D_WIDTH];
      end else if (send[i]) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    if (xfer) begin
      rr_d = (sel == SW'(N-1)) ? '0 : sel + 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      full_q <= '0;
      nh_q   <= '0;
      data_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      nh_q   <= nh_d;
      data_q <= data_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.in_ack      = ack;
  assign bus.out_valid   = any;
  assign bus.out_nexthop = any ? nh_q[sel]   : '0;
  assign bus.out_data    = any ? data_q[sel] : '0;
  assign bus.out_src     = any ? sel         : '0;
  assign bus.tx_count    = cnt_q;
endmodule
